// File: rtl/fpadd_issue_ctrl_if.sv
// Handshake and datapath bundle between the FPADD front end, the issue/collect
// controller and the packed FP16x8 / FP32x4 adder array.
interface fpadd_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [127:0]     cmd_src0;
  logic [127:0]     cmd_src1;
  logic             cmd_mode;
  logic [TAG_W-1:0] cmd_tag;
  logic             flush;

  logic [127:0]     add_src0;
  logic [127:0]     add_src1;
  logic             add_mode;
  logic [127:0]     add_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [127:0]     rsp_data;
  logic             rsp_mode;
  logic [TAG_W-1:0] rsp_tag;

  logic             busy;
  logic [15:0]      op_cnt;

  // Controller side
  modport slave (
    input  cmd_valid, cmd_src0, cmd_src1, cmd_mode, cmd_tag, flush,
    input  add_result, rsp_ready,
    output cmd_ready, add_src0, add_src1, add_mode,
    output rsp_valid, rsp_data, rsp_mode, rsp_tag, busy, op_cnt
  );

  // Front end / adder / consumer side
  modport master (
    output cmd_valid, cmd_src0, cmd_src1, cmd_mode, cmd_tag, flush,
    output add_result, rsp_ready,
    input  cmd_ready, add_src0, add_src1, add_mode,
    input  rsp_valid, rsp_data, rsp_mode, rsp_tag, busy, op_cnt
  );
endinterface

// File: rtl/fpadd_issue_ctrl.sv
// Issue/collect controller for the packed FP add array: holds operands for a
// fixed pipeline latency, captures the sum and returns it with its tag.
//
// state | meaning
// IDLE  | ready for a command, adder inputs hold the last operands
// WAIT  | operands driven, counting down the adder latency
// RESP  | captured sum presented, waiting for rsp_ready
module fpadd_issue_ctrl #(
  parameter int ADD_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fpadd_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(ADD_LAT);

  state_t           state;
  logic [3:0]       lat_cnt;
  logic [TAG_W-1:0] tag_q;
  logic [127:0]     add_src0_q;
  logic [127:0]     add_src1_q;
  logic             add_mode_q;
  logic             rsp_valid_q;
  logic [127:0]     rsp_data_q;
  logic             rsp_mode_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [15:0]      op_cnt_q;

  // Ready is gated by reset and flush so no command slips in while either is active
  assign bus.cmd_ready = rst_n & ~bus.flush & (state == IDLE);
  assign bus.busy      = (state != IDLE);

  assign bus.add_src0  = add_src0_q;
  assign bus.add_src1  = add_src1_q;
  assign bus.add_mode  = add_mode_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_mode  = rsp_mode_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.op_cnt    = op_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= 4'd0;
      tag_q       <= '0;
      add_src0_q  <= '0;
      add_src1_q  <= '0;
      add_mode_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mode_q  <= 1'b0;
      rsp_tag_q   <= '0;
      op_cnt_q    <= 16'd0;
    end else if (bus.flush) begin
      // Operands and the last response payload are kept; only the op is dropped
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      lat_cnt     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            add_src0_q <= bus.cmd_src0;
            add_src1_q <= bus.cmd_src1;
            add_mode_q <= bus.cmd_mode;
            tag_q      <= bus.cmd_tag;
            lat_cnt    <= LAT_INIT;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            rsp_data_q  <= bus.add_result;
            rsp_mode_q  <= add_mode_q;
            rsp_tag_q   <= tag_q;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_cnt_q    <= op_cnt_q + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Bench for fpadd_issue_ctrl: a latency-3 instance and a latency-0 instance,
// each fed by a behavioural packed FP adder pipeline.
module tb_fpadd_issue_ctrl;

  localparam int LAT_A = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpadd_issue_ctrl_if #(.TAG_W(4)) a ();
  fpadd_issue_ctrl_if #(.TAG_W(4)) z ();

  fpadd_issue_ctrl #(.ADD_LAT(LAT_A), .TAG_W(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(a));
  fpadd_issue_ctrl #(.ADD_LAT(0),     .TAG_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(z));

  // IEEE-style value conversions, normal numbers and zero only
  function automatic real fp_to_real(logic [31:0] b, int eb, int mb);
    int  e;
    int  bias;
    real m;
    real v;
    bias = (1 << (eb - 1)) - 1;
    e    = int'((b >> mb) & ((32'd1 << eb) - 32'd1));
    m    = real'(b & ((32'd1 << mb) - 32'd1));
    if (e == 0) return 0.0;
    v = (1.0 + m / (2.0 ** mb)) * (2.0 ** (e - bias));
    if (b[eb + mb]) v = -v;
    return v;
  endfunction

  function automatic logic [31:0] real_to_fp(real v, int eb, int mb);
    real         m;
    int          e;
    int          bias;
    logic [31:0] r;
    bias = (1 << (eb - 1)) - 1;
    if (v == 0.0) return 32'd0;
    m = (v < 0.0) ? -v : v;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    r = 32'(longint'((m - 1.0) * (2.0 ** mb)));
    r = r | (32'(e + bias) << mb);
    if (v < 0.0) r = r | (32'd1 << (eb + mb));
    return r;
  endfunction

  function automatic logic [127:0] fp_add_packed(logic [127:0] x, logic [127:0] y, logic mode);
    logic [127:0] r;
    r = '0;
    if (!mode) begin
      for (int i = 0; i < 8; i++)
        r[16*i +: 16] = 16'(real_to_fp(fp_to_real({16'd0, x[16*i +: 16]}, 5, 10) +
                                       fp_to_real({16'd0, y[16*i +: 16]}, 5, 10), 5, 10));
    end else begin
      for (int i = 0; i < 4; i++)
        r[32*i +: 32] = real_to_fp(fp_to_real(x[32*i +: 32], 8, 23) +
                                   fp_to_real(y[32*i +: 32], 8, 23), 8, 23);
    end
    return r;
  endfunction

  // Random lanes are small integers so every sum is exact in either format
  function automatic logic [127:0] rand_packed(logic mode);
    logic [127:0] r;
    real          v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      v = real'(int'($urandom_range(200)) - 100);
      if (!mode) r[16*i +: 16] = 16'(real_to_fp(v, 5, 10));
      else if (i < 4) r[32*i +: 32] = real_to_fp(v, 8, 23);
    end
    return r;
  endfunction

  // Adder models: LAT_A-stage pipeline and a zero-latency combinational one
  logic [127:0] pipe_a [LAT_A];
  always @(posedge clk) begin
    pipe_a[0] <= fp_add_packed(a.add_src0, a.add_src1, a.add_mode);
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign a.add_result = pipe_a[LAT_A-1];
  assign z.add_result = fp_add_packed(z.add_src0, z.add_src1, z.add_mode);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [127:0] s0, input logic [127:0] s1, input logic md,
                        input logic [3:0] tg, output int acc);
    acc = -1;
    a.cmd_src0  = s0;
    a.cmd_src1  = s1;
    a.cmd_mode  = md;
    a.cmd_tag   = tg;
    a.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (a.cmd_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
    else @(negedge clk);
    a.cmd_valid = 1'b0;
  endtask

  task automatic collect_a(input logic [127:0] s0, input logic [127:0] s1, input logic md,
                           input logic [3:0] tg, input int acc, input int bp);
    logic [127:0] exp_sum;
    int n;
    exp_sum = fp_add_packed(s0, s1, md);
    n = 0;
    while (!a.rsp_valid && n < 40) begin
      chk("hold_src0", a.add_src0, s0);
      chk("hold_src1", a.add_src1, s1);
      chk("hold_mode", a.add_mode, md);
      chk("wait_cmd_ready", a.cmd_ready, 0);
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", cyc - acc, LAT_A + 1);
    chk("rsp_data", a.rsp_data, exp_sum);
    chk("rsp_mode", a.rsp_mode, md);
    chk("rsp_tag", a.rsp_tag, tg);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", a.rsp_valid, 1);
      chk("bp_data", a.rsp_data, exp_sum);
      chk("bp_tag", a.rsp_tag, tg);
      chk("bp_cmd_ready", a.cmd_ready, 0);
    end
    a.rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk("op_cnt", a.op_cnt, exp_cnt);
    chk("post_valid", a.rsp_valid, 0);
    chk("post_cmd_ready", a.cmd_ready, 1);
  endtask

  task automatic do_op_a(input logic [127:0] s0, input logic [127:0] s1, input logic md,
                         input logic [3:0] tg, input int bp);
    int acc;
    a.rsp_ready = (bp == 0);
    send_a(s0, s1, md, tg, acc);
    if (acc >= 0) collect_a(s0, s1, md, tg, acc, bp);
  endtask

  task automatic quiet_a(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, a.rsp_valid, 0);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic         mode;
    logic [3:0]   tag;
    int           acc;
  } exp_t;

  initial begin
    logic [127:0] s0, s1;
    logic         md;
    logic [3:0]   tg;
    int           acc, acc_prev, sent, got;
    exp_t         q[$];
    exp_t         e;

    rst_n = 1'b0;
    a.cmd_valid = 0; a.cmd_src0 = '0; a.cmd_src1 = '0; a.cmd_mode = 0; a.cmd_tag = '0;
    a.flush = 0; a.rsp_ready = 0;
    z.cmd_valid = 0; z.cmd_src0 = '0; z.cmd_src1 = '0; z.cmd_mode = 0; z.cmd_tag = '0;
    z.flush = 0; z.rsp_ready = 0;
    exp_cnt = 16'd0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", a.cmd_ready, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_rsp_valid", a.rsp_valid, 0);
    chk("rst_op_cnt", a.op_cnt, 0);
    chk("rst_add_src0", a.add_src0, 0);
    chk("rst_rsp_data", a.rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", a.cmd_ready, 1);

    // FP16 1.0 + 1.0
    do_op_a({8{16'h3C00}}, {8{16'h3C00}}, 1'b0, 4'd5, 0);
    chk("fp16_const", a.rsp_data, {8{16'h4000}});
    chk("fp16_cnt", a.op_cnt, 1);

    // FP32 1.0 + 2.0
    do_op_a({4{32'h3F800000}}, {4{32'h40000000}}, 1'b1, 4'd9, 0);
    chk("fp32_const", a.rsp_data, {4{32'h40400000}});
    chk("fp32_mode", a.rsp_mode, 1);

    // Backpressure for 10 cycles
    do_op_a(rand_packed(1'b0), rand_packed(1'b0), 1'b0, 4'd3, 10);

    for (int k = 0; k < 16; k++) begin
      md = 1'($urandom_range(1));
      do_op_a(rand_packed(md), rand_packed(md), md, 4'($urandom_range(15)),
              int'($urandom_range(3)));
    end

    // Flush during WAIT
    a.rsp_ready = 1'b1;
    send_a(rand_packed(1'b0), rand_packed(1'b0), 1'b0, 4'd7, acc);
    a.flush = 1'b1;
    @(negedge clk);
    a.flush = 1'b0;
    chk("flw_busy", a.busy, 0);
    chk("flw_valid", a.rsp_valid, 0);
    chk("flw_cnt", a.op_cnt, exp_cnt);
    quiet_a("flw_no_rsp", LAT_A + 3);
    chk("flw_cnt_after", a.op_cnt, exp_cnt);

    // Flush during RESP with rsp_ready high
    a.rsp_ready = 1'b0;
    send_a(rand_packed(1'b1), rand_packed(1'b1), 1'b1, 4'd2, acc);
    for (int i = 0; i < 40 && !a.rsp_valid; i++) @(negedge clk);
    chk("flr_reached_resp", a.rsp_valid, 1);
    a.flush = 1'b1;
    a.rsp_ready = 1'b1;
    @(negedge clk);
    a.flush = 1'b0;
    a.rsp_ready = 1'b0;
    chk("flr_valid", a.rsp_valid, 0);
    chk("flr_busy", a.busy, 0);
    chk("flr_cnt", a.op_cnt, exp_cnt);
    quiet_a("flr_no_rsp", 3);

    // Command held across a flush is taken only once flush drops
    s0 = rand_packed(1'b0);
    s1 = rand_packed(1'b0);
    a.cmd_src0 = s0; a.cmd_src1 = s1; a.cmd_mode = 1'b0; a.cmd_tag = 4'd11;
    a.cmd_valid = 1'b1;
    a.flush = 1'b1;
    a.rsp_ready = 1'b1;
    #1;
    chk("flc_cmd_ready", a.cmd_ready, 0);
    @(negedge clk);
    chk("flc_not_taken", a.busy, 0);
    a.flush = 1'b0;
    #1;
    chk("flc_ready_back", a.cmd_ready, 1);
    @(negedge clk);
    a.cmd_valid = 1'b0;
    acc = cyc;
    chk("flc_taken", a.busy, 1);
    collect_a(s0, s1, 1'b0, 4'd11, acc, 0);

    // Counter wrap: preload near the top, then two completions
    force dut.op_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_cnt_q;
    exp_cnt = 16'hFFFE;
    chk("wrap_preload", a.op_cnt, 16'hFFFE);
    do_op_a(rand_packed(1'b1), rand_packed(1'b1), 1'b1, 4'd1, 0);
    do_op_a(rand_packed(1'b0), rand_packed(1'b0), 1'b0, 4'd2, 0);
    chk("wrap_zero", a.op_cnt, 16'h0000);
    do_op_a(rand_packed(1'b0), rand_packed(1'b0), 1'b0, 4'd4, 1);

    // Reset during WAIT
    a.rsp_ready = 1'b1;
    send_a(rand_packed(1'b1), rand_packed(1'b1), 1'b1, 4'd13, acc);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_cmd_ready", a.cmd_ready, 0);
    chk("mrst_busy", a.busy, 0);
    chk("mrst_valid", a.rsp_valid, 0);
    chk("mrst_add_src0", a.add_src0, 0);
    chk("mrst_add_src1", a.add_src1, 0);
    chk("mrst_add_mode", a.add_mode, 0);
    chk("mrst_rsp_data", a.rsp_data, 0);
    chk("mrst_rsp_mode", a.rsp_mode, 0);
    chk("mrst_rsp_tag", a.rsp_tag, 0);
    chk("mrst_op_cnt", a.op_cnt, 0);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    quiet_a("mrst_no_rsp", LAT_A + 3);

    // Zero-latency instance, back-to-back with rsp_ready tied high
    z.rsp_ready = 1'b1;
    acc_prev = -1;
    sent = 0;
    got = 0;
    for (int i = 0; i < 100 && got < 8; i++) begin
      if (sent == 8) z.cmd_valid = 1'b0;
      if (z.rsp_valid) begin
        if (q.size() == 0) begin
          chk("z_spurious_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("z_rsp_data", z.rsp_data, e.data);
          chk("z_rsp_mode", z.rsp_mode, e.mode);
          chk("z_rsp_tag", z.rsp_tag, e.tag);
          chk("z_latency", cyc - e.acc, 1);
          got++;
        end
      end
      if (sent < 8 && z.cmd_ready) begin
        md = 1'(sent & 1);
        z.cmd_src0 = rand_packed(md);
        z.cmd_src1 = rand_packed(md);
        z.cmd_mode = md;
        z.cmd_tag  = 4'(sent + 6);
        z.cmd_valid = 1'b1;
        e.data = fp_add_packed(z.cmd_src0, z.cmd_src1, md);
        e.mode = md;
        e.tag  = z.cmd_tag;
        e.acc  = cyc + 1;
        q.push_back(e);
        if (acc_prev >= 0) chk("z_period", e.acc - acc_prev, 3);
        acc_prev = e.acc;
        sent++;
      end
      @(negedge clk);
    end
    z.cmd_valid = 1'b0;
    chk("z_all_returned", got, 8);
    chk("z_op_cnt", z.op_cnt, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpadd_issue_ctrl.md
# fpadd_issue_ctrl

Issue/collect controller on the operand side of the packed FP add datapath. It accepts one 128-bit add command at a time over a valid/ready handshake, then drives and holds operands plus mode on the packed subword adder inputs. After the adder's fixed pipeline latency it captures the adder output and returns it, with the command tag, over a valid/ready response handshake. It sits between the FPADD instruction front end and the packed FP16×8 / FP32×4 adder array.

## Interface
- ADD_LAT, 3: adder pipeline depth in cycles from operand change to valid result; legal 0..15.
- TAG_W, 4: width of the command/response tag.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_src0, cmd_src1  in  128  packed operands.
- cmd_mode  in  1  0 = FP16×8 lanes, 1 = FP32×4 lanes.
- cmd_tag  in  TAG_W  opaque ID returned with the result.
- flush  in  1  drop any in-flight or pending operation.
- add_src0, add_src1  out  128  operands to the adder array.
- add_mode  out  1  lane mode to the adder array.
- add_result  in  128  packed sum from the adder array.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  128  captured packed sum.
- rsp_mode, rsp_tag  out  1 / TAG_W  mode and tag of the returned op.
- busy  out  1  state ≠ IDLE.
- op_cnt  out  16  number of completed response handshakes, wraps.

## Operation
- States: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready = 1 (and 0 while rst_n = 0).
  - On cmd_valid & cmd_ready, register cmd_src0/src1/mode/tag into add_src0/add_src1/add_mode/tag reg.
  - Load the latency counter with ADD_LAT and go to WAIT.
- WAIT:
  - cmd_ready = 0. add_src0/add_src1/add_mode are held stable.
  - Counter decrements each cycle while nonzero.
  - In the cycle where the counter is 0, add_result is sampled into rsp_data at that edge, rsp_mode/rsp_tag are loaded, and the FSM goes to RESP.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_mode and rsp_tag stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: op_cnt increments (0xFFFF wraps to 0x0000) and the FSM goes to IDLE.
  - A new command is not accepted in the same cycle; cmd_ready rises on the following cycle.
- add_src*/add_mode keep their last values after completion. They change only on command acceptance.
- flush, any state, flush has priority over every other event:
  - Next state IDLE, rsp_valid = 0, counter cleared.
  - op_cnt unchanged, even if rsp_ready is high in the same cycle.
  - A command presented while flush = 1 is not accepted: cmd_ready is forced to 0 when flush = 1.
- The controller does no arithmetic. Lane packing is identical on both sides: lane i is bits [16i+15:16i] in FP16 mode and [32i+31:32i] in FP32 mode.

## Timing
- Reset values: state IDLE, add_src0 = add_src1 = 0, add_mode = 0, rsp_valid = 0, rsp_data = 0, rsp_mode = 0, rsp_tag = 0, op_cnt = 0, busy = 0.
- A reset mid-operation discards the op exactly like flush and also clears op_cnt.
- Latency: the command is accepted at edge T. Operands appear at T. add_result is sampled at edge T+ADD_LAT+1. rsp_valid is high from T+ADD_LAT+1.
- ADD_LAT = 0: a single WAIT cycle; result sampled at T+1.
- Throughput with rsp_ready tied high: one op per ADD_LAT+3 cycles.
- All outputs are registered except cmd_ready and busy, which decode state (cmd_ready also gated by rst_n and flush).

## Test plan
The bench models the adder as an ADD_LAT-stage pipeline that returns the lane-wise FP sum.
- FP16, ADD_LAT = 3: src0 = src1 = {8{16'h3C00}}, tag = 5, rsp_ready = 1 → rsp_valid rises 4 cycles after acceptance with rsp_data = {8{16'h4000}}, rsp_tag = 5, rsp_mode = 0, op_cnt = 1.
- FP32: src0 = {4{32'h3F800000}}, src1 = {4{32'h40000000}}, mode = 1 → rsp_data = {4{32'h40400000}}, rsp_mode = 1; add_src* are stable for every WAIT cycle.
- Backpressure: rsp_ready held 0 for 10 cycles → rsp_valid, rsp_data and rsp_tag stay constant and cmd_ready = 0 throughout; on rsp_ready = 1, one handshake, op_cnt +1, cmd_ready = 1 on the next cycle.
- Flush: flush pulsed in WAIT, and separately in RESP with rsp_ready = 1 → IDLE next cycle, no response, op_cnt unchanged. A cmd_valid held during flush is accepted only after flush drops.
- Wrap and reset: force 65536 completions → op_cnt returns to 0. Assert rst_n = 0 in WAIT → all outputs at their reset values after the edge, and no response is issued.
- ADD_LAT = 0 build: back-to-back commands with rsp_ready = 1 → results sampled one cycle after acceptance, one op every 3 cycles, and tags returned in order.
